mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one load/store at a time onto the DataMemory
// port (MRd/MWrt/FUNC3/ADDR/W_DATA/R_DATA) and returns a one-cycle response.
// Ports: CLK/RESET (sync, active-high); REQ_* request handshake from the
// pipeline; RSP_* completion pulse with load data / error flag; MRd, MWrt,
// FUNC3, ADDR, W_DATA, R_DATA connect straight to the DataMemory.
module mem_access_unit #(
  parameter int RD_LATENCY = 1,  // cycles MRd is held before R_DATA is sampled (1..15)
  parameter int WR_CYCLES  = 2   // cycles MWrt is held per store (1..15)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNC3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MRd,
  output logic        MWrt,
  output logic [2:0]  FUNC3,
  output logic [31:0] ADDR,
  output logic [31:0] W_DATA,
  input  logic [31:0] R_DATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mrd_q;
  logic        mwrt_q;
  logic        rsp_vld_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        illegal_d;
  logic [3:0]  cnt_d;

  // Width-code / alignment legality of the request currently presented.
  always_comb begin
    illegal_d = 1'b1;
    case (REQ_FUNC3)
      3'b000:  illegal_d = 1'b0;                     // B
      3'b001:  illegal_d = REQ_ADDR[0];              // H
      3'b010:  illegal_d = (REQ_ADDR[1:0] != 2'b00); // W
      3'b100:  illegal_d = REQ_WE;                   // BU: loads only
      3'b101:  illegal_d = REQ_WE | REQ_ADDR[0];     // HU: loads only
      default: illegal_d = 1'b1;
    endcase
  end

  assign cnt_d = REQ_WE ? 4'(WR_CYCLES) : 4'(RD_LATENCY);

  // Ready is gated by RESET so nothing is accepted while reset is held.
  assign REQ_READY = (state_q == IDLE) && !RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      mrd_q       <= 1'b0;
      mwrt_q      <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            // Memory-facing fields are latched on every accept and held until
            // the next one; W_DATA stays zero for loads.
            we_q    <= REQ_WE;
            func3_q <= REQ_FUNC3;
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WE ? REQ_WDATA : 32'd0;
            if (illegal_d) begin
              // Rejected accesses skip the memory entirely.
              state_q     <= RESP;
              rsp_vld_q   <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= cnt_d;
              mrd_q   <= ~REQ_WE;
              mwrt_q  <= REQ_WE;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // Last strobe cycle: R_DATA reflects the held address now.
            mrd_q       <= 1'b0;
            mwrt_q      <= 1'b0;
            rsp_vld_q   <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'd0 : R_DATA;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_vld_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign RSP_VALID = rsp_vld_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign MRd       = mrd_q;
  assign MWrt      = mwrt_q;
  assign FUNC3     = func3_q;
  assign ADDR      = addr_q;
  assign W_DATA    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int RD_LAT = 1;
  localparam int WR_CYC = 2;
  localparam int NVEC   = 21;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNC3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        MRd;
  logic        MWrt;
  logic [2:0]  FUNC3;
  logic [31:0] ADDR;
  logic [31:0] W_DATA;
  logic [31:0] R_DATA;

  mem_access_unit #(.RD_LATENCY(RD_LAT), .WR_CYCLES(WR_CYC)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNC3(REQ_FUNC3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MRd(MRd), .MWrt(MWrt), .FUNC3(FUNC3), .ADDR(ADDR), .W_DATA(W_DATA),
    .R_DATA(R_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural DataMemory: 64 bytes, handles width and extension itself.
  logic [7:0] pmem [0:63];

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    int i;
    logic [7:0] b0, b1, b2, b3;
    i  = int'(a[5:0]);
    b0 = pmem[i];
    b1 = pmem[(i + 1) % 64];
    b2 = pmem[(i + 2) % 64];
    b3 = pmem[(i + 3) % 64];
    case (f3)
      3'b000:  mem_rd = {{24{b0[7]}}, b0};
      3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rd = {b3, b2, b1, b0};
      3'b100:  mem_rd = {24'd0, b0};
      3'b101:  mem_rd = {16'd0, b1, b0};
      default: mem_rd = 32'd0;
    endcase
  endfunction

  assign R_DATA = mem_rd(ADDR, FUNC3);

  always @(posedge CLK) begin
    if (MWrt) begin
      pmem[int'(ADDR[5:0])] <= W_DATA[7:0];
      if (FUNC3 == 3'b001 || FUNC3 == 3'b010)
        pmem[(int'(ADDR[5:0]) + 1) % 64] <= W_DATA[15:8];
      if (FUNC3 == 3'b010) begin
        pmem[(int'(ADDR[5:0]) + 2) % 64] <= W_DATA[23:16];
        pmem[(int'(ADDR[5:0]) + 3) % 64] <= W_DATA[31:24];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          mrd;
    int          mwrt;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t q [$];

  // Monitor state, written only by the monitor process.
  int cyc_cnt = 0;
  int n_mrd   = 0;
  int n_mwrt  = 0;
  bit bus_bad = 1'b0;
  bit rdy_bad = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (q.size() != 0) begin
      cyc_cnt++;
      if (MRd)  n_mrd++;
      if (MWrt) n_mwrt++;
      if ((MRd || MWrt) &&
          (ADDR !== q[0].addr || FUNC3 !== q[0].f3 || (MRd && MWrt) ||
           W_DATA !== (q[0].we ? q[0].wdata : 32'd0)))
        bus_bad = 1'b1;
      if (RSP_VALID && (MRd || MWrt)) bus_bad = 1'b1;
      if (REQ_READY && (MRd || MWrt || RSP_VALID)) rdy_bad = 1'b1;
    end
    if (RSP_VALID) begin
      chk("rsp_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_err",     32'(RSP_ERR), 32'(e.err));
        chk("rsp_rdata",   RSP_RDATA, e.rdata);
        chk("rsp_latency", 32'(cyc_cnt), 32'(e.lat));
        chk("mrd_cycles",  32'(n_mrd),  32'(e.mrd));
        chk("mwrt_cycles", 32'(n_mwrt), 32'(e.mwrt));
        chk("bus_stable",  32'(bus_bad), 32'd0);
        chk("ready_busy",  32'(rdy_bad), 32'd0);
        cyc_cnt = 0;
        n_mrd   = 0;
        n_mwrt  = 0;
        bus_bad = 1'b0;
        rdy_bad = 1'b0;
      end
    end
  end

  function automatic exp_t mk_exp(input vec_t v, input int lat);
    exp_t e;
    e.we    = v.we;
    e.f3    = v.f3;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.err   = v.err;
    e.rdata = v.rdata;
    e.lat   = lat;
    e.mrd   = (!v.err && !v.we) ? RD_LAT : 0;
    e.mwrt  = (!v.err &&  v.we) ? WR_CYC : 0;
    return e;
  endfunction

  function automatic int std_lat(input vec_t v);
    return v.err ? 1 : ((v.we ? WR_CYC : RD_LAT) + 1);
  endfunction

  task automatic drive(input vec_t v);
    REQ_WE    = v.we;
    REQ_FUNC3 = v.f3;
    REQ_ADDR  = v.addr;
    REQ_WDATA = v.wdata;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk("rsp_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_req(input vec_t v);
    @(negedge CLK);
    chk("ready_idle", 32'(REQ_READY), 32'd1);
    drive(v);
    REQ_VALID = 1'b1;
    q.push_back(mk_exp(v, std_lat(v)));
    @(negedge CLK);
    REQ_VALID = 1'b0;
    wait_empty(40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vs;
    bit   seen;
    int   n;

    for (int i = 0; i < 64; i++) pmem[i] = 8'h00;

    //          we    f3      addr   wdata          err   rdata
    tbl[0]  = '{1'b1, 3'b000, 32'd5,  32'h0000_00F0, 1'b0, 32'h0000_0000}; // SB
    tbl[1]  = '{1'b1, 3'b001, 32'd0,  32'h0000_00F0, 1'b0, 32'h0000_0000}; // SH
    tbl[2]  = '{1'b0, 3'b001, 32'd0,  32'h0,         1'b0, 32'h0000_00F0}; // LH
    tbl[3]  = '{1'b0, 3'b010, 32'd6,  32'h0,         1'b1, 32'h0000_0000}; // LW misaligned
    tbl[4]  = '{1'b0, 3'b011, 32'd0,  32'h0,         1'b1, 32'h0000_0000}; // bad code
    tbl[5]  = '{1'b1, 3'b100, 32'd0,  32'h0000_0055, 1'b1, 32'h0000_0000}; // store BU
    tbl[6]  = '{1'b1, 3'b010, 32'd8,  32'h8081_8283, 1'b0, 32'h0000_0000}; // SW
    tbl[7]  = '{1'b0, 3'b010, 32'd8,  32'h0,         1'b0, 32'h8081_8283}; // LW
    tbl[8]  = '{1'b0, 3'b000, 32'd8,  32'h0,         1'b0, 32'hFFFF_FF83}; // LB
    tbl[9]  = '{1'b0, 3'b100, 32'd9,  32'h0,         1'b0, 32'h0000_0082}; // LBU
    tbl[10] = '{1'b0, 3'b001, 32'd10, 32'h0,         1'b0, 32'hFFFF_8081}; // LH
    tbl[11] = '{1'b0, 3'b101, 32'd10, 32'h0,         1'b0, 32'h0000_8081}; // LHU
    tbl[12] = '{1'b0, 3'b001, 32'd1,  32'h0,         1'b1, 32'h0000_0000}; // LH odd
    tbl[13] = '{1'b1, 3'b001, 32'd3,  32'h0000_1234, 1'b1, 32'h0000_0000}; // SH odd
    tbl[14] = '{1'b0, 3'b000, 32'd5,  32'h0,         1'b0, 32'hFFFF_FFF0}; // LB
    tbl[15] = '{1'b0, 3'b100, 32'd5,  32'h0,         1'b0, 32'h0000_00F0}; // LBU
    tbl[16] = '{1'b1, 3'b110, 32'd0,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000}; // bad code
    tbl[17] = '{1'b0, 3'b111, 32'd0,  32'h0,         1'b1, 32'h0000_0000}; // bad code
    tbl[18] = '{1'b0, 3'b101, 32'd1,  32'h0,         1'b1, 32'h0000_0000}; // LHU odd
    tbl[19] = '{1'b0, 3'b010, 32'd0,  32'h0,         1'b0, 32'h0000_00F0}; // LW, untouched
    tbl[20] = '{1'b0, 3'b010, 32'd4,  32'h0,         1'b0, 32'h0000_F000}; // LW

    RESET     = 1'b1;
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
    REQ_FUNC3 = 3'b000;
    REQ_ADDR  = 32'd0;
    REQ_WDATA = 32'd0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready",  32'(REQ_READY), 32'd0);
    chk("reset_rspvld", 32'(RSP_VALID), 32'd0);
    chk("reset_rsperr", 32'(RSP_ERR),   32'd0);
    chk("reset_rdata",  RSP_RDATA,      32'd0);
    chk("reset_strobe", 32'({MRd, MWrt}), 32'd0);
    chk("reset_func3",  32'(FUNC3),     32'd0);
    chk("reset_addr",   ADDR,           32'd0);
    chk("reset_wdata",  W_DATA,         32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("ready_after_reset", 32'(REQ_READY), 32'd1);

    // Table-driven accesses.
    for (int i = 0; i < NVEC; i++) do_req(tbl[i]);

    // Address and width code persist after completion.
    @(negedge CLK);
    chk("hold_addr",  ADDR,          32'd4);
    chk("hold_func3", 32'(FUNC3),    32'd2);

    // Back-to-back loads with REQ_VALID held high.
    va = '{1'b0, 3'b010, 32'd8, 32'h0, 1'b0, 32'h8081_8283};
    vb = '{1'b0, 3'b100, 32'd9, 32'h0, 1'b0, 32'h0000_0082};
    @(negedge CLK);
    chk("b2b_ready_a", 32'(REQ_READY), 32'd1);
    drive(va);
    REQ_VALID = 1'b1;
    q.push_back(mk_exp(va, std_lat(va)));
    @(negedge CLK);
    drive(vb);
    // B latency counts from A's response: one idle cycle, then the access.
    q.push_back(mk_exp(vb, RD_LAT + 2));
    n = 0;
    while (q.size() > 1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_first_done", 32'(q.size()), 32'd1);
    @(negedge CLK);
    chk("b2b_ready_b", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    wait_empty(40);

    // Reset during a store's access phase.
    vs = '{1'b1, 3'b010, 32'd12, 32'hDEAD_BEEF, 1'b0, 32'h0};
    @(negedge CLK);
    drive(vs);
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("abort_mwrt_before", 32'(MWrt), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_mwrt_after",  32'(MWrt),      32'd0);
    chk("abort_rspvld",      32'(RSP_VALID), 32'd0);
    chk("abort_ready_rst",   32'(REQ_READY), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_ready_after", 32'(REQ_READY), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      if (RSP_VALID || MWrt) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
